fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, address of the first fetch after reset.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc_sum  input  8  sequential next PC from the external 8-bit adder (pc + 1).
REQ-006 pc  output  8  current fetch PC; drives adder operand a.
REQ-007 branch_valid  input  1  redirect request, one-cycle pulse.
REQ-008 branch_target  input  8  redirect address, sampled when branch_valid=1.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  8  request address.
REQ-011 imem_ack  input  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-012 imem_rdata  input  INSTR_W  fetched instruction word.
REQ-013 instr_valid  output  1  decode-side valid.
REQ-014 instr  output  INSTR_W  instruction presented to decode.
REQ-015 instr_pc  output  8  address of instr.
REQ-016 instr_ready  input  1  decode accepts; transfer occurs when instr_valid & instr_ready.

Function
REQ-017 FSM states: FETCH (request outstanding), HOLD (instruction presented), DRAIN (discarding the outstanding request after a redirect).
REQ-018 imem_req is 1 in FETCH and DRAIN, 0 in HOLD; once asserted, imem_req and imem_addr stay stable until imem_ack.
REQ-019 imem_addr equals pc in all states.
REQ-020 FETCH, imem_ack=1, branch_valid=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc_sum, next HOLD; latency one cycle from ack to instr_valid.
REQ-021 FETCH, imem_ack=1, branch_valid=1: data discarded, pc<=branch_target, stay FETCH.
REQ-022 FETCH, imem_ack=0, branch_valid=1: pend_target<=branch_target, next DRAIN; pc unchanged.
REQ-023 DRAIN, branch_valid=1: pend_target<=branch_target (latest redirect wins).
REQ-024 DRAIN, imem_ack=1: data discarded, pc<=(branch_valid ? branch_target : pend_target), next FETCH.
REQ-025 HOLD, branch_valid=0, instr_ready=1: instr_valid<=0, next FETCH; instr and instr_pc hold their last values.
REQ-026 HOLD, instr_ready=0: instr_valid, instr and instr_pc held stable.
REQ-027 HOLD, branch_valid=1: instr_valid<=0, pc<=branch_target, next FETCH; branch takes priority, and a coincident instr_ready does not count as a transfer.
REQ-028 PC arithmetic is 8-bit modulo: pc 8'hFF advances to 8'h00 through pc_sum with no flag.
REQ-029 imem_ack outside FETCH/DRAIN is ignored.

Reset
REQ-030 While rst_n=0 at a clock edge: state<=FETCH, pc<=RESET_PC, pend_target<=0, instr_valid<=0, instr<=0, instr_pc<=0.
REQ-031 Reset mid-operation abandons any outstanding request or held instruction without a drain; the first cycle after reset shows imem_req=1 and imem_addr=RESET_PC.

Structure
REQ-032 Shared package cpu_pkg holds ADDR_W=8, INSTR_W default and the fetch state enum.
REQ-033 fetch_unit instantiates no sub-module; the existing adder is instantiated beside it at the CPU top, with a=pc, b=8'h01 and c=pc_sum.

Verification
REQ-034 Reset release, ack with rdata=16'hA5A5 in the first cycle -> next cycle instr_valid=1, instr=16'hA5A5, instr_pc=8'h00, pc=8'h01.
REQ-035 Backpressure: instr_ready=0 for 5 cycles -> instr, instr_pc and instr_valid stable and imem_req=0 throughout; ready=1 -> FETCH at pc=8'h01.
REQ-036 Redirect with no ack: in FETCH at pc=8'h04, branch_target=8'h40 and ack delayed 3 cycles -> imem_addr stays 8'h04 until ack, data discarded, next request at 8'h40.
REQ-037 Flush: branch_target=8'h20 in HOLD with instr_ready=1 -> no transfer counted, instr_valid=0 next cycle, next imem_addr=8'h20.
REQ-038 Wrap: branch to 8'hFF, ack -> instr_pc=8'hFF, pc=8'h00.
REQ-039 Reset asserted in DRAIN -> next cycle state FETCH, imem_addr=RESET_PC, instr_valid=0, and a late ack is treated as the response to the new fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, default instruction width and fetch FSM encoding.
package cpu_pkg;

  localparam int ADDR_W          = 8;
  localparam int INSTR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, one instruction held for decode; instr_valid one cycle after imem_ack.
// Backpressure: no new request is issued while decode has not taken the held instruction (instr_ready=0).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int                INSTR_W  = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_sum,
  output logic [ADDR_W-1:0]  pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pend_target_q, pend_target_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack && !branch_valid) begin
          state_d = ST_HOLD;
        end else if (!imem_ack && branch_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (branch_valid || instr_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath next values; pc only moves when the outstanding request completes or none is in flight
  always_comb begin
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          if (branch_valid) begin
            pc_d = branch_target;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_sum;
          end
        end else if (branch_valid) begin
          pend_target_d = branch_target;
        end
      end
      ST_HOLD: begin
        if (branch_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = branch_target;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (branch_valid) begin
          pend_target_d = branch_target;
        end
        if (imem_ack) begin
          pc_d = branch_valid ? branch_target : pend_target_q;
        end
      end
      default: begin
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Output logic
  always_comb begin
    imem_req    = (state_q != ST_HOLD);
    imem_addr   = pc_q;
    pc          = pc_q;
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit; the external pc+1 adder is modelled beside the DUT.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_sum;
  logic [7:0]  pc;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign pc_sum = pc + 8'h01;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sum        (pc_sum),
    .pc            (pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  // Inputs applied before an edge, outputs expected just after it
  typedef struct {
    logic        rst_n;
    logic        bv;
    logic [7:0]  bt;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [7:0]  e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic bv, input logic [7:0] bt, input logic ack,
                     input logic [15:0] rd, input logic rdy, input logic e_req,
                     input logic [7:0] e_addr, input logic e_valid, input logic [15:0] e_instr,
                     input logic [7:0] e_ipc);
    vec_t v;
    v.rst_n = r; v.bv = bv; v.bt = bt; v.ack = ack; v.rdata = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    rst_n = v.rst_n; branch_valid = v.bv; branch_target = v.bt;
    imem_ack = v.ack; imem_rdata = v.rdata; instr_ready = v.rdy;
    @(posedge clk);
    #1;
    check($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(v.e_req));
    check($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(v.e_addr));
    check($sformatf("v%0d.pc", i), 32'(pc), 32'(v.e_addr));
    check($sformatf("v%0d.instr_valid", i), 32'(instr_valid), 32'(v.e_valid));
    check($sformatf("v%0d.instr", i), 32'(instr), 32'(v.e_instr));
    check($sformatf("v%0d.instr_pc", i), 32'(instr_pc), 32'(v.e_ipc));
  endtask

  initial begin
    rst_n = 1'b0; branch_valid = 1'b0; branch_target = 8'h00;
    imem_ack = 1'b0; imem_rdata = 16'h0000; instr_ready = 1'b0;

    //   rst bv  bt     ack rdata     rdy  req addr   vld instr     ipc
    add(0, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h00,  0, 16'h0000, 8'h00); // 0 reset
    add(1, 0, 8'h00, 1, 16'hA5A5, 0,   0, 8'h01,  1, 16'hA5A5, 8'h00); // 1 first fetch
    // backpressure loop runs here
    add(1, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h01,  0, 16'hA5A5, 8'h00); // 2 accept
    add(1, 0, 8'h00, 1, 16'h1111, 0,   0, 8'h02,  1, 16'h1111, 8'h01);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h02,  0, 16'h1111, 8'h01);
    add(1, 0, 8'h00, 1, 16'h2222, 1,   0, 8'h03,  1, 16'h2222, 8'h02);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h03,  0, 16'h2222, 8'h02);
    add(1, 0, 8'h00, 1, 16'h3333, 1,   0, 8'h04,  1, 16'h3333, 8'h03);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h04,  0, 16'h3333, 8'h03); // 8 FETCH @04
    add(1, 1, 8'h40, 0, 16'h0000, 0,   1, 8'h04,  0, 16'h3333, 8'h03); // 9 redirect, no ack
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h04,  0, 16'h3333, 8'h03);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h04,  0, 16'h3333, 8'h03);
    add(1, 0, 8'h00, 1, 16'hDEAD, 1,   1, 8'h40,  0, 16'h3333, 8'h03); // 12 late ack dropped
    add(1, 0, 8'h00, 1, 16'hBEEF, 0,   0, 8'h41,  1, 16'hBEEF, 8'h40);
    add(1, 1, 8'h20, 1, 16'h0000, 1,   1, 8'h20,  0, 16'hBEEF, 8'h40); // 14 flush in HOLD
    add(1, 1, 8'hFF, 1, 16'hBAD0, 0,   1, 8'hFF,  0, 16'hBEEF, 8'h40); // 15 ack+branch drops data
    add(1, 0, 8'h00, 1, 16'h7777, 0,   0, 8'h00,  1, 16'h7777, 8'hFF); // 16 wrap
    add(1, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h00,  0, 16'h7777, 8'hFF);
    add(1, 1, 8'h60, 0, 16'h0000, 0,   1, 8'h00,  0, 16'h7777, 8'hFF); // 18 DRAIN
    add(1, 1, 8'h70, 0, 16'h0000, 0,   1, 8'h00,  0, 16'h7777, 8'hFF); // latest wins
    add(1, 0, 8'h00, 1, 16'h1234, 0,   1, 8'h70,  0, 16'h7777, 8'hFF);
    add(1, 1, 8'h80, 0, 16'h0000, 0,   1, 8'h70,  0, 16'h7777, 8'hFF);
    add(1, 1, 8'h90, 1, 16'h5678, 0,   1, 8'h90,  0, 16'h7777, 8'hFF); // branch with drain ack
    add(1, 1, 8'h10, 0, 16'h0000, 0,   1, 8'h90,  0, 16'h7777, 8'hFF); // 23 DRAIN
    add(0, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h00,  0, 16'h0000, 8'h00); // 24 reset in DRAIN
    add(1, 0, 8'h00, 1, 16'hCAFE, 0,   0, 8'h01,  1, 16'hCAFE, 8'h00); // late ack = new fetch
    add(0, 0, 8'h00, 0, 16'h0000, 1,   1, 8'h00,  0, 16'h0000, 8'h00); // reset in HOLD

    run_vec(0);
    run_vec(1);

    // Decode stalls while stray acks arrive: held instruction must not move
    for (int c = 0; c < 5; c++) begin
      instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hFFFF; branch_valid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d.imem_req", c), 32'(imem_req), 32'd0);
      check($sformatf("bp%0d.instr_valid", c), 32'(instr_valid), 32'd1);
      check($sformatf("bp%0d.instr", c), 32'(instr), 32'h0000A5A5);
      check($sformatf("bp%0d.instr_pc", c), 32'(instr_pc), 32'h00);
      check($sformatf("bp%0d.imem_addr", c), 32'(imem_addr), 32'h01);
    end

    for (int i = 2; i < vecs.size(); i++) begin
      run_vec(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
